level_control: RTL and testbench

LEVEL_CONTROL -- requirements
Module: level_control

---
 rtl/game_pkg.sv | 21 ++
 rtl/frame_timer.sv | 26 ++
 rtl/level_control.sv | 170 +++++++++++++++++
 tb/tb_level_control.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the game level sequencer: state encoding,
// start keycode and initial lives.
package game_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT1 = 4'd1,
        S_PLAY1 = 4'd2,
        S_INIT2 = 4'd3,
        S_PLAY2 = 4'd4,
        S_INIT3 = 4'd5,
        S_PLAY3 = 4'd6,
        S_BREAK = 4'd7,
        S_WON   = 4'd8,
        S_LOST  = 4'd9
    } level_state_t;

    localparam logic [7:0] START_KEY_DEFAULT  = 8'h28;
    localparam int         LIVES_INIT_DEFAULT = 3;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; done is high while the count sits at zero.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/level_control.sv
// Game level sequencer: start, three levels, lives, win/lose.
// Optional inter-level pause is enabled by defining LEVEL_BREAK_EN.
module level_control
    import game_pkg::*;
#(
    parameter logic [7:0] START_KEY    = START_KEY_DEFAULT,
    parameter int         LIVES_INIT   = LIVES_INIT_DEFAULT,
    parameter int         BREAK_FRAMES = 120
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       is_dead,
    input  logic       is_dead2,
    input  logic       is_dead3,
    input  logic       boss_dead,
    input  logic       player_hit,
    output logic       draw_level1,
    output logic       draw_level2,
    output logic       draw_level3,
    output logic       set_motion_1,
    output logic       set_motion_2,
    output logic       set_motion_3,
    output logic       clear_kills,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       game_won,
    output logic [3:0] fsm_state
);

    if (BREAK_FRAMES < 1 || LIVES_INIT < 1 || LIVES_INIT > 3) begin : g_bad_cfg
        $error("level_control: BREAK_FRAMES must be >= 1 and LIVES_INIT in 1..3");
    end

    level_state_t state, next_state;
    logic [1:0]   guard, next_guard, next_lives;
    logic         armed, clear_now;

`ifdef LEVEL_BREAK_EN
    localparam int BW = $clog2(BREAK_FRAMES + 1);
    logic [1:0] brk_level, next_brk_level;
    logic       break_done;

    frame_timer #(.W(BW)) u_break_timer (
        .clk        (frame_clk),
        .rst_n      (Reset_n),
        .load       (next_state == S_BREAK && state != S_BREAK),
        .load_value (BW'(BREAK_FRAMES - 1)),
        .done       (break_done)
    );
`endif

    assign armed     = (guard == 2'd2);
    assign fsm_state = state;

    always_comb begin
        clear_now = 1'b0;
        case (state)
            S_PLAY1: clear_now = is_dead && is_dead2;
            S_PLAY2: clear_now = is_dead3;
            S_PLAY3: clear_now = boss_dead;
            default: clear_now = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        next_lives = lives;
        next_guard = guard;
`ifdef LEVEL_BREAK_EN
        next_brk_level = brk_level;
`endif
        case (state)
            S_IDLE: if (keycode == START_KEY) begin
                next_state = S_INIT1;
                next_lives = 2'(LIVES_INIT);
            end
            S_INIT1: begin next_state = S_PLAY1; next_guard = 2'd0; end
            S_INIT2: begin next_state = S_PLAY2; next_guard = 2'd0; end
            S_INIT3: begin next_state = S_PLAY3; next_guard = 2'd0; end
            S_PLAY1, S_PLAY2, S_PLAY3: begin
                // Kills and hits are only honoured once the guard has expired;
                // a clear outranks a simultaneous hit.
                if (!armed) begin
                    next_guard = guard + 2'd1;
                end else if (clear_now) begin
                    case (state)
`ifdef LEVEL_BREAK_EN
                        S_PLAY1: begin next_state = S_BREAK; next_brk_level = 2'd2; end
                        S_PLAY2: begin next_state = S_BREAK; next_brk_level = 2'd3; end
`else
                        S_PLAY1: next_state = S_INIT2;
                        S_PLAY2: next_state = S_INIT3;
`endif
                        default: next_state = S_WON;
                    endcase
                end else if (player_hit) begin
                    if (lives > 2'd1) begin
                        next_lives = lives - 2'd1;
                        case (state)
                            S_PLAY1: next_state = S_INIT1;
                            S_PLAY2: next_state = S_INIT2;
                            default: next_state = S_INIT3;
                        endcase
                    end else begin
                        next_lives = 2'd0;
                        next_state = S_LOST;
                    end
                end
            end
`ifdef LEVEL_BREAK_EN
            S_BREAK: if (break_done) begin
                next_state = (brk_level == 2'd2) ? S_INIT2 : S_INIT3;
            end
`endif
            S_WON, S_LOST: if (keycode == START_KEY) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they line up with the registered state.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            lives        <= 2'd0;
            guard        <= 2'd0;
            draw_level1  <= 1'b0;
            draw_level2  <= 1'b0;
            draw_level3  <= 1'b0;
            set_motion_1 <= 1'b0;
            set_motion_2 <= 1'b0;
            set_motion_3 <= 1'b0;
            clear_kills  <= 1'b0;
            level        <= 2'd0;
            game_over    <= 1'b0;
            game_won     <= 1'b0;
`ifdef LEVEL_BREAK_EN
            brk_level    <= 2'd0;
`endif
        end else begin
            state        <= next_state;
            lives        <= next_lives;
            guard        <= next_guard;
            draw_level1  <= (next_state == S_INIT1) || (next_state == S_PLAY1);
            draw_level2  <= (next_state == S_INIT2) || (next_state == S_PLAY2);
            draw_level3  <= (next_state == S_INIT3) || (next_state == S_PLAY3);
            set_motion_1 <= (next_state == S_INIT1);
            set_motion_2 <= (next_state == S_INIT2);
            set_motion_3 <= (next_state == S_INIT3);
            clear_kills  <= (next_state == S_INIT1) || (next_state == S_INIT2) ||
                            (next_state == S_INIT3);
            game_over    <= (next_state == S_LOST);
            game_won     <= (next_state == S_WON);
            case (next_state)
                S_INIT1, S_PLAY1: level <= 2'd1;
                S_INIT2, S_PLAY2: level <= 2'd2;
                S_INIT3, S_PLAY3: level <= 2'd3;
`ifdef LEVEL_BREAK_EN
                S_BREAK:          level <= next_brk_level;
`endif
                default:          level <= 2'd0;
            endcase
`ifdef LEVEL_BREAK_EN
            brk_level    <= next_brk_level;
`endif
        end
    end

endmodule

// File: tb/tb_level_control.sv
// Directed bench for level_control: start, guard frames, hits, win/lose,
// asynchronous reset mid-level.
module tb_level_control;
    import game_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       is_dead = 1'b0, is_dead2 = 1'b0, is_dead3 = 1'b0, boss_dead = 1'b0;
    logic       player_hit = 1'b0;
    logic       draw_level1, draw_level2, draw_level3;
    logic       set_motion_1, set_motion_2, set_motion_3;
    logic       clear_kills, game_over, game_won;
    logic [1:0] level_o, lives_o;
    logic [3:0] fsm_state;

    int total = 0;
    int bad   = 0;

    level_control dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .keycode      (keycode),
        .is_dead      (is_dead),
        .is_dead2     (is_dead2),
        .is_dead3     (is_dead3),
        .boss_dead    (boss_dead),
        .player_hit   (player_hit),
        .draw_level1  (draw_level1),
        .draw_level2  (draw_level2),
        .draw_level3  (draw_level3),
        .set_motion_1 (set_motion_1),
        .set_motion_2 (set_motion_2),
        .set_motion_3 (set_motion_3),
        .clear_kills  (clear_kills),
        .level        (level_o),
        .lives        (lives_o),
        .game_over    (game_over),
        .game_won     (game_won),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    logic [16:0] obs;
    assign obs = {fsm_state, draw_level1, draw_level2, draw_level3,
                  set_motion_1, set_motion_2, set_motion_3,
                  clear_kills, game_over, game_won, level_o, lives_o};

    // expected vector: {state, draw[1:3], set_motion[1:3], clear_kills, over, won, level, lives}
    function automatic logic [16:0] ev(input logic [2:0] d, input logic [2:0] s,
                                       input logic ck, input logic go, input logic gw,
                                       input logic [1:0] lvl, input logic [1:0] lv,
                                       input level_state_t st);
        return {4'(st), d, s, ck, go, gw, lvl, lv};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #3;
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE)) begin
            bad++; $display("FAIL reset_values got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE));
        end
        @(negedge frame_clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_start();
        keycode = 8'h00;
        tick();
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE)) begin
            bad++; $display("FAIL idle_no_key got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE));
        end
        keycode = 8'h28;
        tick();
        total++;
        if (obs !== ev(3'b100, 3'b100, 1, 0, 0, 2'd1, 2'd3, S_INIT1)) begin
            bad++; $display("FAIL start_init1 got=%h want=%h", obs, ev(3'b100, 3'b100, 1, 0, 0, 2'd1, 2'd3, S_INIT1));
        end
        keycode = 8'h00;
        tick();
        total++;
        if (obs !== ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1)) begin
            bad++; $display("FAIL start_play1 got=%h want=%h", obs, ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1));
        end
    endtask

    task automatic test_guard();
        is_dead = 1'b1; is_dead2 = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1)) begin
            bad++; $display("FAIL guard_frame1 got=%h want=%h", obs, ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1));
        end
        tick();
        total++;
        if (obs !== ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1)) begin
            bad++; $display("FAIL guard_frame2 got=%h want=%h", obs, ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1));
        end
        tick();
        total++;
        if (obs !== ev(3'b010, 3'b010, 1, 0, 0, 2'd2, 2'd3, S_INIT2)) begin
            bad++; $display("FAIL clear1_init2 got=%h want=%h", obs, ev(3'b010, 3'b010, 1, 0, 0, 2'd2, 2'd3, S_INIT2));
        end
        is_dead = 1'b0; is_dead2 = 1'b0;
        tick();
        player_hit = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b010, 3'b000, 0, 0, 0, 2'd2, 2'd3, S_PLAY2)) begin
            bad++; $display("FAIL hit_in_guard got=%h want=%h", obs, ev(3'b010, 3'b000, 0, 0, 0, 2'd2, 2'd3, S_PLAY2));
        end
        player_hit = 1'b0;
        tick();
    endtask

    task automatic test_hit();
        player_hit = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b010, 3'b010, 1, 0, 0, 2'd2, 2'd2, S_INIT2)) begin
            bad++; $display("FAIL hit_restart_l2 got=%h want=%h", obs, ev(3'b010, 3'b010, 1, 0, 0, 2'd2, 2'd2, S_INIT2));
        end
        player_hit = 1'b0;
        ticks(3);
        player_hit = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b010, 3'b010, 1, 0, 0, 2'd2, 2'd1, S_INIT2)) begin
            bad++; $display("FAIL hit_lives1 got=%h want=%h", obs, ev(3'b010, 3'b010, 1, 0, 0, 2'd2, 2'd1, S_INIT2));
        end
        player_hit = 1'b0;
        ticks(3);
        player_hit = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 1, 0, 2'd0, 2'd0, S_LOST)) begin
            bad++; $display("FAIL hit_lost got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 1, 0, 2'd0, 2'd0, S_LOST));
        end
        tick();
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 1, 0, 2'd0, 2'd0, S_LOST)) begin
            bad++; $display("FAIL lost_no_underflow got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 1, 0, 2'd0, 2'd0, S_LOST));
        end
        player_hit = 1'b0;
        keycode = 8'h28;
        tick();
        keycode = 8'h00;
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE)) begin
            bad++; $display("FAIL lost_to_idle got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE));
        end
    endtask

    task automatic test_win();
        keycode = 8'h28;
        tick();
        keycode = 8'h00;
        ticks(3);
        is_dead = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1)) begin
            bad++; $display("FAIL partial_kill got=%h want=%h", obs, ev(3'b100, 3'b000, 0, 0, 0, 2'd1, 2'd3, S_PLAY1));
        end
        is_dead2 = 1'b1;
        tick();
        is_dead = 1'b0; is_dead2 = 1'b0;
        ticks(3);
        is_dead3 = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b001, 3'b001, 1, 0, 0, 2'd3, 2'd3, S_INIT3)) begin
            bad++; $display("FAIL clear2_init3 got=%h want=%h", obs, ev(3'b001, 3'b001, 1, 0, 0, 2'd3, 2'd3, S_INIT3));
        end
        is_dead3 = 1'b0;
        tick();
        total++;
        if (obs !== ev(3'b001, 3'b000, 0, 0, 0, 2'd3, 2'd3, S_PLAY3)) begin
            bad++; $display("FAIL play3 got=%h want=%h", obs, ev(3'b001, 3'b000, 0, 0, 0, 2'd3, 2'd3, S_PLAY3));
        end
        ticks(2);
        is_dead3 = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b001, 3'b000, 0, 0, 0, 2'd3, 2'd3, S_PLAY3)) begin
            bad++; $display("FAIL wrong_kill_l3 got=%h want=%h", obs, ev(3'b001, 3'b000, 0, 0, 0, 2'd3, 2'd3, S_PLAY3));
        end
        is_dead3 = 1'b0;
        boss_dead = 1'b1; player_hit = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 1, 2'd0, 2'd3, S_WON)) begin
            bad++; $display("FAIL clear_beats_hit got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 1, 2'd0, 2'd3, S_WON));
        end
        boss_dead = 1'b0; player_hit = 1'b0;
        tick();
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 1, 2'd0, 2'd3, S_WON)) begin
            bad++; $display("FAIL won_hold got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 1, 2'd0, 2'd3, S_WON));
        end
        keycode = 8'h28;
        tick();
        keycode = 8'h00;
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd3, S_IDLE)) begin
            bad++; $display("FAIL won_to_idle got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd3, S_IDLE));
        end
    endtask

    task automatic test_async_reset();
        keycode = 8'h28;
        tick();
        keycode = 8'h00;
        ticks(3);
        is_dead = 1'b1; is_dead2 = 1'b1;
        tick();
        is_dead = 1'b0; is_dead2 = 1'b0;
        ticks(2);
        total++;
        if (obs !== ev(3'b010, 3'b000, 0, 0, 0, 2'd2, 2'd3, S_PLAY2)) begin
            bad++; $display("FAIL pre_reset_play2 got=%h want=%h", obs, ev(3'b010, 3'b000, 0, 0, 0, 2'd2, 2'd3, S_PLAY2));
        end
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE)) begin
            bad++; $display("FAIL async_reset got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE));
        end
        @(negedge frame_clk);
        Reset_n = 1'b1;
        tick();
        total++;
        if (obs !== ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE)) begin
            bad++; $display("FAIL after_release got=%h want=%h", obs, ev(3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0, S_IDLE));
        end
        keycode = 8'h28;
        tick();
        keycode = 8'h00;
        total++;
        if (obs !== ev(3'b100, 3'b100, 1, 0, 0, 2'd1, 2'd3, S_INIT1)) begin
            bad++; $display("FAIL restart_after_reset got=%h want=%h", obs, ev(3'b100, 3'b100, 1, 0, 0, 2'd1, 2'd3, S_INIT1));
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_guard();
        test_hit();
        test_win();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
